// File: rtl/channel_sidereplay_pkg.sv
// Shared definitions for the channel replay side: FIFO word layout helpers
// and the output-stage state encoding.
package rr_replay_pkg;

  // Metadata bits carried above the payload in each recorded FIFO word.
  localparam int REC_META_BITS = 2;

  // Bit position of the ispkt flag in a {ispkt, busy, data} FIFO word.
  function automatic int rec_ispkt_pos(input int width);
    return width + 1;
  endfunction

  // Bit position of the busy flag in a {ispkt, busy, data} FIFO word.
  function automatic int rec_busy_pos(input int width);
    return width;
  endfunction

  // Output-stage state: SEND means a replayed packet is waiting for acceptance.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } rep_state_e;

endpackage

// File: rtl/channel_sidereplay_out_reg.sv
// Holding register for one replayed packet with a valid/ready handshake,
// plus a wrapping count of completed handshakes.
module replay_out_reg
  import rr_replay_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_load,
  input  logic [WIDTH-1:0]     i_data,
  input  logic                 i_ready,
  output logic                 o_valid,
  output logic [WIDTH-1:0]     o_data,
  output logic [CNT_WIDTH-1:0] o_cnt
);

  rep_state_e           r_state;
  rep_state_e           w_state_nxt;
  logic [WIDTH-1:0]     r_data;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 w_fire;

  assign w_fire = (r_state == ST_SEND) && i_ready;

  // State register; reset drops any outstanding packet immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state: load only from IDLE, leave SEND only on acceptance.
  always_comb begin
    // NOTE: the default assignment first keeps this block free of latches.
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (i_load)  w_state_nxt = ST_SEND;
      ST_SEND: if (i_ready) w_state_nxt = ST_IDLE;
      default:              w_state_nxt = ST_IDLE;
    endcase
  end

  // Payload capture; held stable for the whole SEND period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            r_data <= '0;
    else if (i_load && r_state == ST_IDLE) r_data <= i_data;
  end

  // Completed-handshake counter, wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_cnt <= '0;
    else if (w_fire) r_cnt <= r_cnt + CNT_WIDTH'(1);
  end

  assign o_valid = (r_state == ST_SEND);
  assign o_data  = r_data;
  assign o_cnt   = r_cnt;

endmodule

// File: rtl/channel_sidereplay.sv
// Replay side of one recorded channel: pops {ispkt, busy, data} entries from
// the replay FIFO under the global row-advance handshake and re-issues packets.
// Optional stall counter enabled by defining FPGARR_REPLAY_STALL_CNT_EN.
module channel_sidereplay
  import rr_replay_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rep_valid,
  input  logic                 rep_ispkt,
  input  logic                 rep_busy,
  input  logic [WIDTH-1:0]     rep_data,
  output logic                 rep_ready,
  output logic                 row_ok,
  input  logic                 row_go,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  input  logic                 out_ready,
  output logic                 idle,
  output logic [CNT_WIDTH-1:0] pkt_cnt,
  output logic                 err_proto,
  output logic [CNT_WIDTH-1:0] stall_cnt
);

  logic w_out_valid;
  logic w_busy_eff;
  logic w_row_ok;
  logic w_pop;
  logic w_load;
  logic w_bad_row_go;
  logic w_bad_entry;
  logic r_err_proto;

  // A packet entry is never legitimately busy; such an entry is treated as busy=0.
  assign w_busy_eff = rep_busy && !rep_ispkt;

  // Only the registered valid is used, so a completion unblocks a busy=0
  // row one cycle later, matching how the recorder observed it.
  assign w_row_ok = rep_valid && (!w_out_valid || w_busy_eff);
  assign w_pop    = row_go && w_row_ok;
  assign w_load   = w_pop && rep_ispkt;

  assign w_bad_row_go = row_go && rep_valid && !w_row_ok;
  assign w_bad_entry  = rep_valid && rep_ispkt && rep_busy;

  replay_out_reg #(
    .WIDTH     (WIDTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_out_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_load),
    .i_data  (rep_data),
    .i_ready (out_ready),
    .o_valid (w_out_valid),
    .o_data  (out_data),
    .o_cnt   (pkt_cnt)
  );

  // Sticky protocol-error flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           r_err_proto <= 1'b0;
    else if (w_bad_row_go || w_bad_entry) r_err_proto <= 1'b1;
  end

`ifdef FPGARR_REPLAY_STALL_CNT_EN
  logic [CNT_WIDTH-1:0] r_stall_cnt;

  // Saturating count of cycles where a head entry is present but blocked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_stall_cnt <= '0;
    else if (rep_valid && !w_row_ok && (r_stall_cnt != '1))
      r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
  end

  assign stall_cnt = r_stall_cnt;
`else
  assign stall_cnt = '0;
`endif

  assign rep_ready = w_pop;
  assign row_ok    = w_row_ok;
  assign out_valid = w_out_valid;
  assign idle      = !w_out_valid;
  assign err_proto = r_err_proto;

  // Output-stage view used by the handshake properties below.
  rep_state_e w_state;
  assign w_state = rep_state_e'(w_out_valid);

  // A stalled packet stays valid with unchanged payload.
  a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (w_state == ST_SEND && !out_ready) |=> (w_state == ST_SEND && $stable(out_data)));

  // A new packet is only loaded while the output stage is empty.
  a_load_idle: assert property (@(posedge clk) disable iff (!rst_n)
    w_load |-> (w_state == ST_IDLE));

endmodule

// File: tb/tb_channel_sidereplay.sv
// Directed testbench for channel_sidereplay (WIDTH=32, CNT_WIDTH=4).
module tb_channel_sidereplay;

  localparam int WIDTH     = 32;
  localparam int CNT_WIDTH = 4;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 rep_valid, rep_ispkt, rep_busy;
  logic [WIDTH-1:0]     rep_data;
  logic                 rep_ready, row_ok, row_go;
  logic                 out_valid, out_ready, idle, err_proto;
  logic [WIDTH-1:0]     out_data;
  logic [CNT_WIDTH-1:0] pkt_cnt, stall_cnt;

  int n_vec = 0;
  int n_err = 0;

  channel_sidereplay #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rep_valid (rep_valid),
    .rep_ispkt (rep_ispkt),
    .rep_busy  (rep_busy),
    .rep_data  (rep_data),
    .rep_ready (rep_ready),
    .row_ok    (row_ok),
    .row_go    (row_go),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .idle      (idle),
    .pkt_cnt   (pkt_cnt),
    .err_proto (err_proto),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  // Advance one clock; leaves time at 1 unit past the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_head();
    rep_valid = 1'b0; rep_ispkt = 1'b0; rep_busy = 1'b0; row_go = 1'b0;
  endtask

  // Pop a packet entry; the packet is visible on return.
  task automatic load_pkt(input logic [WIDTH-1:0] d);
    rep_valid = 1'b1; rep_ispkt = 1'b1; rep_busy = 1'b0; rep_data = d; row_go = 1'b1;
    step();
    clear_head();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; out_ready = 1'b0; rep_data = '0;
    clear_head();
    #3;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", out_valid); end
    n_vec++; if (out_data !== 32'h0) begin n_err++; $display("FAIL rst_data: got %h want 0", out_data); end
    n_vec++; if (pkt_cnt !== 4'd0) begin n_err++; $display("FAIL rst_pkt_cnt: got %0d want 0", pkt_cnt); end
    n_vec++; if (err_proto !== 1'b0) begin n_err++; $display("FAIL rst_err: got %b want 0", err_proto); end
    n_vec++; if (stall_cnt !== 4'd0) begin n_err++; $display("FAIL rst_stall: got %0d want 0", stall_cnt); end
    n_vec++; if (idle !== 1'b1) begin n_err++; $display("FAIL rst_idle: got %b want 1", idle); end
    n_vec++; if (rep_ready !== 1'b0 || row_ok !== 1'b0) begin n_err++; $display("FAIL rst_ready_ok: got %b%b want 00", rep_ready, row_ok); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic_packet();
    rep_valid = 1'b1; rep_ispkt = 1'b1; rep_busy = 1'b0; rep_data = 32'hDEADBEEF; row_go = 1'b1;
    #1;
    n_vec++; if (rep_ready !== 1'b1) begin n_err++; $display("FAIL basic_pop: got %b want 1", rep_ready); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_not_yet: got %b want 0", out_valid); end
    step();
    clear_head();
    #1;
    n_vec++; if (rep_ready !== 1'b0) begin n_err++; $display("FAIL basic_pop_pulse: got %b want 0", rep_ready); end
    n_vec++; if (out_valid !== 1'b1 || out_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL basic_visible: got %b/%h want 1/deadbeef", out_valid, out_data); end
    for (int i = 0; i < 3; i++) begin
      step();
      n_vec++; if (out_valid !== 1'b1 || out_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL basic_hold%0d: got %b/%h want 1/deadbeef", i, out_valid, out_data); end
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_vec++; if (out_valid !== 1'b0 || idle !== 1'b1) begin n_err++; $display("FAIL basic_drop: got valid %b idle %b want 0 1", out_valid, idle); end
    n_vec++; if (pkt_cnt !== 4'd1) begin n_err++; $display("FAIL basic_cnt: got %0d want 1", pkt_cnt); end
  endtask

  task automatic test_busy0_block();
    load_pkt(32'hA5A5A5A5);
    rep_valid = 1'b1; rep_ispkt = 1'b0; rep_busy = 1'b0; rep_data = 32'h0;
    #1;
    n_vec++; if (row_ok !== 1'b0 || rep_ready !== 1'b0) begin n_err++; $display("FAIL busy0_blocked: got ok %b ready %b want 0 0", row_ok, rep_ready); end
    out_ready = 1'b1;
    #1;
    n_vec++; if (row_ok !== 1'b0) begin n_err++; $display("FAIL busy0_same_cycle: got %b want 0", row_ok); end
    step();
    out_ready = 1'b0;
    n_vec++; if (row_ok !== 1'b1) begin n_err++; $display("FAIL busy0_next_cycle: got %b want 1", row_ok); end
    row_go = 1'b1;
    #1;
    n_vec++; if (rep_ready !== 1'b1) begin n_err++; $display("FAIL busy0_pop: got %b want 1", rep_ready); end
    step();
    clear_head();
    n_vec++; if (out_valid !== 1'b0 || pkt_cnt !== 4'd2) begin n_err++; $display("FAIL busy0_after: got valid %b cnt %0d want 0 2", out_valid, pkt_cnt); end
  endtask

  task automatic test_busy1_bubble();
    load_pkt(32'h12345678);
    rep_valid = 1'b1; rep_ispkt = 1'b0; rep_busy = 1'b1; rep_data = 32'hFFFF0000; row_go = 1'b1;
    #1;
    n_vec++; if (row_ok !== 1'b1 || rep_ready !== 1'b1) begin n_err++; $display("FAIL bubble_pop: got ok %b ready %b want 1 1", row_ok, rep_ready); end
    step();
    n_vec++; if (out_valid !== 1'b1 || out_data !== 32'h12345678) begin n_err++; $display("FAIL bubble_hold: got %b/%h want 1/12345678", out_valid, out_data); end
    out_ready = 1'b1;
    #1;
    n_vec++; if (rep_ready !== 1'b1) begin n_err++; $display("FAIL bubble_simul_pop: got %b want 1", rep_ready); end
    step();
    clear_head();
    out_ready = 1'b0;
    n_vec++; if (out_valid !== 1'b0 || pkt_cnt !== 4'd3) begin n_err++; $display("FAIL bubble_simul_done: got valid %b cnt %0d want 0 3", out_valid, pkt_cnt); end
    n_vec++; if (err_proto !== 1'b0) begin n_err++; $display("FAIL bubble_no_err: got %b want 0", err_proto); end
  endtask

  task automatic test_cnt_wrap();
    logic [CNT_WIDTH-1:0] exp_cnt;
    exp_cnt = 4'd3;
    for (int i = 0; i < 16; i++) begin
      load_pkt(32'(i));
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      exp_cnt = exp_cnt + 4'd1;
      n_vec++; if (pkt_cnt !== exp_cnt) begin n_err++; $display("FAIL wrap_cnt%0d: got %0d want %0d", i, pkt_cnt, exp_cnt); end
    end
  endtask

  task automatic test_async_reset();
    load_pkt(32'hCAFEF00D);
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL areset_pre: got %b want 1", out_valid); end
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (out_valid !== 1'b0 || out_data !== 32'h0 || pkt_cnt !== 4'd0) begin n_err++; $display("FAIL areset_drop: got %b/%h/%0d want 0/0/0", out_valid, out_data, pkt_cnt); end
    #2 rst_n = 1'b1;
    step();
  endtask

  task automatic test_go_empty();
    rep_valid = 1'b0; row_go = 1'b1;
    #1;
    n_vec++; if (rep_ready !== 1'b0) begin n_err++; $display("FAIL empty_go_pop: got %b want 0", rep_ready); end
    step();
    row_go = 1'b0;
    n_vec++; if (err_proto !== 1'b0) begin n_err++; $display("FAIL empty_go_err: got %b want 0", err_proto); end
  endtask

  task automatic test_stall();
    logic [CNT_WIDTH-1:0] exp5, exp17;
`ifdef FPGARR_REPLAY_STALL_CNT_EN
    exp5 = 4'd5; exp17 = 4'd15;
`else
    exp5 = 4'd0; exp17 = 4'd0;
`endif
    load_pkt(32'h0000BEEF);
    rep_valid = 1'b1; rep_ispkt = 1'b0; rep_busy = 1'b0;
    repeat (5) step();
    n_vec++; if (stall_cnt !== exp5) begin n_err++; $display("FAIL stall_5: got %0d want %0d", stall_cnt, exp5); end
    repeat (12) step();
    n_vec++; if (stall_cnt !== exp17) begin n_err++; $display("FAIL stall_sat: got %0d want %0d", stall_cnt, exp17); end
    clear_head();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_err_row_go();
    load_pkt(32'h0BADF00D);
    rep_valid = 1'b1; rep_ispkt = 1'b0; rep_busy = 1'b0; row_go = 1'b1;
    #1;
    n_vec++; if (rep_ready !== 1'b0) begin n_err++; $display("FAIL errgo_no_pop: got %b want 0", rep_ready); end
    step();
    clear_head();
    n_vec++; if (err_proto !== 1'b1) begin n_err++; $display("FAIL errgo_set: got %b want 1", err_proto); end
    n_vec++; if (out_valid !== 1'b1 || out_data !== 32'h0BADF00D) begin n_err++; $display("FAIL errgo_out: got %b/%h want 1/0badf00d", out_valid, out_data); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    repeat (2) step();
    n_vec++; if (err_proto !== 1'b1) begin n_err++; $display("FAIL errgo_sticky: got %b want 1", err_proto); end
  endtask

  task automatic test_err_bad_entry();
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    step();
    n_vec++; if (err_proto !== 1'b0) begin n_err++; $display("FAIL bad_cleared: got %b want 0", err_proto); end
    load_pkt(32'h55AA55AA);
    rep_valid = 1'b1; rep_ispkt = 1'b1; rep_busy = 1'b1; rep_data = 32'h11111111;
    #1;
    n_vec++; if (row_ok !== 1'b0) begin n_err++; $display("FAIL bad_as_busy0: got %b want 0", row_ok); end
    step();
    clear_head();
    n_vec++; if (err_proto !== 1'b1) begin n_err++; $display("FAIL bad_set: got %b want 1", err_proto); end
    n_vec++; if (out_data !== 32'h55AA55AA) begin n_err++; $display("FAIL bad_data_kept: got %h want 55aa55aa", out_data); end
  endtask

  initial begin
    test_reset();
    test_basic_packet();
    test_busy0_block();
    test_busy1_bubble();
    test_cnt_wrap();
    test_async_reset();
    test_go_empty();
    test_stall();
    test_err_row_go();
    test_err_bad_entry();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/channel_sidereplay.md
Name: channel_sidereplay

Overview:
- Replay-side counterpart of the per-channel recorder. It consumes recorded entries {ispkt, busy, data} from the channel's replay FIFO and re-issues packets onto the channel with a valid/ready handshake.
- It enforces the recorded partial ordering through a global row-advance handshake shared by all channel instances: rows pop together on every channel only when each channel reports row_ok.
- One instance per replayed channel. It sits between the replay FIFO and the CL-facing channel port.

Parameters:
- WIDTH, 32, packet payload width in bits.
- CNT_WIDTH, 32, width of the completed-packet counter and the stall counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- rep_valid  in  1  replay FIFO head entry is present.
- rep_ispkt  in  1  head entry carries a packet for this channel.
- rep_busy  in  1  head entry's recorded busy bit: previous packet was still outstanding at this row.
- rep_data  in  WIDTH  head entry payload.
- rep_ready  out  1  pop strobe to the replay FIFO.
- row_ok  out  1  this channel permits the current row to advance.
- row_go  in  1  global AND of all channels' row_ok, supplied by the ordering logic.
- out_valid  out  1  replayed packet valid toward the consumer.
- out_data  out  WIDTH  replayed packet payload.
- out_ready  in  1  consumer accepts the packet.
- idle  out  1  no packet outstanding; equals !out_valid.
- pkt_cnt  out  CNT_WIDTH  number of completed handshakes.
- err_proto  out  1  sticky protocol-error flag.
- stall_cnt  out  CNT_WIDTH  stall cycles (see Optional Feature).

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_data=0, pkt_cnt=0, err_proto=0, stall_cnt=0. Derived outputs follow: rep_ready=0, row_ok=0 (or as derived), idle=1. Reset asserted mid-handshake drops out_valid immediately and loses the packet.
- Two states, encoded by the out_valid register:
  - IDLE (out_valid=0).
  - SEND (out_valid=1).
- row_ok (combinational) = rep_valid && (!out_valid || (rep_busy && !rep_ispkt)).
  - row_ok uses only the registered out_valid, never out_ready.
  - A completion in cycle N therefore unblocks a busy=0 row at the earliest in cycle N+1. This matches the recorder's rule that completion is observed one cycle later.
- rep_ready = row_go && row_ok. The entry pops only on this strobe.
- IDLE -> SEND: pop with rep_ispkt=1. At the next edge, out_data<=rep_data and out_valid<=1. The packet becomes visible one cycle after the pop.
- SEND -> IDLE: out_valid && out_ready. Also pkt_cnt<=pkt_cnt+1, wrapping modulo 2^CNT_WIDTH.
- out_data is held stable while out_valid=1. out_valid never deasserts without out_ready.
- Pop with rep_ispkt=0:
  - No output change.
  - If rep_busy=1, the pop is legal in SEND: other channels proceed while this packet is in flight.
  - If rep_busy=0, the pop requires IDLE.
- err_proto is set (sticky until reset) on either condition:
  - row_go=1 while rep_valid=1 and row_ok=0 (the ordering logic violated the handshake; no pop occurs).
  - A head entry with rep_ispkt=1 and rep_busy=1 (the recorder never produces this); it is treated as busy=0.
- row_go while rep_valid=0: no pop, no error.
- Simultaneous completion and pop of a busy=1 bubble in the same cycle: both take effect.

Optional Feature:
- Macro: FPGARR_REPLAY_STALL_CNT_EN.
- Defined: stall_cnt increments every cycle with rep_valid=1 and row_ok=0. It saturates at all-ones and clears only on reset.
- Undefined: no counter logic is built and stall_cnt is tied to 0.

Decomposition:
- Package rr_replay_pkg holds:
  - REC_META_BITS=2.
  - Bit-position constants REC_ISPKT_POS=WIDTH+1 and REC_BUSY_POS=WIDTH, as functions of WIDTH, for splitting the FIFO word {ispkt, busy, data}.
  - An enum for IDLE/SEND, used in assertions.
- One sub-module: replay_out_reg, the holding register with its valid/ready handshake and pkt_cnt. The top holds the row_ok/rep_ready/err logic and the optional stall counter.

Test Plan:
- Reset then an entry {1,0,0xDEADBEEF} with row_go=1 -> rep_ready pulses 1 cycle; out_valid=1 with out_data=0xDEADBEEF next cycle; held 3 cycles with out_ready=0; drops after out_ready=1; pkt_cnt=1.
- Packet outstanding (out_ready=0) with head {0,0,x} -> row_ok=0, no pop. out_ready=1 in cycle N -> row_ok=1 in cycle N+1, not in N.
- Packet outstanding with head {0,1,x} -> row_ok=1, pop occurs, out_valid stays 1 and out_data is unchanged.
- Force row_go=1 while row_ok=0 -> no pop, err_proto=1 and remains 1. Head {1,1,x} -> err_proto=1.
- 2^CNT_WIDTH completions with CNT_WIDTH=4 -> pkt_cnt wraps 15->0. rst_n=0 mid-SEND -> out_valid=0 asynchronously, before the next clock edge.
- With FPGARR_REPLAY_STALL_CNT_EN defined: 5 blocked cycles -> stall_cnt=5; with CNT_WIDTH=4, it saturates at 15. Without the macro -> stall_cnt=0 throughout.
